mem_port_arbiter: RTL and testbench

//  Shares one single-ported instruction/data memory between IF-stage fetch and MEM-stage lw/sw.

---
 rtl/mem_port_arbiter.sv | 214 +++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported instruction/data memory between the IF-stage fetch
//   port and the MEM-stage load/store port. The data port has fixed priority
//   because it carries the older instruction. A registered IDLE/BUSY/RESP FSM
//   drives a req/ack handshake toward memory. stall_o is raised while either
//   requester is waiting for its acknowledge.
//
//   Ports
//     clk_i, rst_i            clock, synchronous active-low reset
//     if_req_i/if_addr_i      fetch request + address (held until if_ack_o)
//     if_rdata_o/if_ack_o     fetched word, 1-cycle completion pulse
//     dm_req_i/dm_we_i        data request, 1=store 0=load (held until dm_ack_o)
//     dm_addr_i/dm_wdata_i    data address, store data
//     dm_rdata_o/dm_ack_o     load data (0 on store), 1-cycle completion pulse
//     mem_req_o/mem_we_o      memory request (held until mem_ack_i), write enable
//     mem_addr_o/mem_wdata_o  memory address, write data
//     mem_rdata_i/mem_ack_i   memory read data, 1-cycle completion
//     stall_o                 combinational pipeline stall
//     err_o                   sticky watchdog timeout flag
//     perf_conf_o/perf_dm_o   performance counters (zero unless enabled)
//
//   Build option: define MEM_PORT_ARBITER_PERF_EN to build the perf counters.
//   TIMEOUT = 0 disables the memory-ack watchdog.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_ack_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              dm_ack_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i,
  output logic              stall_o,
  output logic              err_o,
  output logic [31:0]       perf_conf_o,
  output logic [31:0]       perf_dm_o
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_e;
  typedef enum logic {OWN_IF, OWN_DM} owner_e;

  // Counter must be able to represent TIMEOUT; keep at least one bit when disabled.
  localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              if_ack_q, if_ack_d;
  logic              dm_ack_q, dm_ack_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              err_q, err_d;
  logic [WD_W-1:0]   wd_q, wd_d;

  logic              grant_if, grant_dm, done;
  logic [DATA_W-1:0] cap;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_ack_d    = 1'b0;
    dm_ack_d    = 1'b0;
    if_rdata_d  = '0;
    dm_rdata_d  = '0;
    err_d       = err_q;
    wd_d        = wd_q;
    grant_if    = 1'b0;
    grant_dm    = 1'b0;
    done        = 1'b0;
    cap         = '0;

    unique case (state_q)
      S_IDLE: begin
        grant_dm = dm_req_i;
        grant_if = if_req_i & ~dm_req_i;
      end
      S_BUSY: begin
        if (mem_ack_i) begin
          done = 1'b1;
          cap  = mem_we_q ? '0 : mem_rdata_i;
        end else if ((TIMEOUT != 0) && (wd_q == WD_LAST)) begin
          done  = 1'b1;
          err_d = 1'b1;
        end else if (TIMEOUT != 0) begin
          wd_d = wd_q + WD_W'(1);
        end
        if (done) begin
          state_d   = S_RESP;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          if (owner_q == OWN_IF) begin
            if_ack_d   = 1'b1;
            if_rdata_d = cap;
          end else begin
            dm_ack_d   = 1'b1;
            dm_rdata_d = cap;
          end
        end
      end
      S_RESP: begin
        // Owner's request is still high this cycle; only the other port may be granted.
        state_d  = S_IDLE;
        grant_if = (owner_q == OWN_DM) & if_req_i;
        grant_dm = (owner_q == OWN_IF) & dm_req_i;
      end
      default: state_d = S_IDLE;
    endcase

    if (grant_dm) begin
      state_d     = S_BUSY;
      owner_d     = OWN_DM;
      mem_req_d   = 1'b1;
      mem_we_d    = dm_we_i;
      mem_addr_d  = dm_addr_i;
      mem_wdata_d = dm_wdata_i;
      wd_d        = '0;
    end else if (grant_if) begin
      state_d     = S_BUSY;
      owner_d     = OWN_IF;
      mem_req_d   = 1'b1;
      mem_we_d    = 1'b0;
      mem_addr_d  = if_addr_i;
      mem_wdata_d = '0;
      wd_d        = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q     <= S_IDLE;
      owner_q     <= OWN_IF;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      err_q       <= 1'b0;
      wd_q        <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_ack_q    <= if_ack_d;
      dm_ack_q    <= dm_ack_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      err_q       <= err_d;
      wd_q        <= wd_d;
    end
  end

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign if_ack_o    = if_ack_q;
  assign dm_ack_o    = dm_ack_q;
  assign if_rdata_o  = if_rdata_q;
  assign dm_rdata_o  = dm_rdata_q;
  assign err_o       = err_q;
  assign stall_o     = (if_req_i & ~if_ack_q) | (dm_req_i & ~dm_ack_q);

`ifdef MEM_PORT_ARBITER_PERF_EN
  logic [31:0] perf_conf_q, perf_dm_q;

  // Fetch blocked: fetch waiting while the data port owns an active access.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      perf_conf_q <= '0;
      perf_dm_q   <= '0;
    end else begin
      if (if_req_i && (owner_q != OWN_IF) && (state_q != S_IDLE))
        perf_conf_q <= perf_conf_q + 32'd1;
      if (dm_ack_q)
        perf_dm_q <= perf_dm_q + 32'd1;
    end
  end

  assign perf_conf_o = perf_conf_q;
  assign perf_dm_o   = perf_dm_q;
`else
  assign perf_conf_o = '0;
  assign perf_dm_o   = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  localparam int TMO = 4;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } acc_t;

  logic        clk_i;
  logic        rst_i;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_rdata_o;
  logic        if_ack_o;
  logic        dm_req_i;
  logic        dm_we_i;
  logic [31:0] dm_addr_i;
  logic [31:0] dm_wdata_i;
  logic [31:0] dm_rdata_o;
  logic        dm_ack_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;
  logic        mem_ack_i;
  logic        stall_o;
  logic        err_o;
  logic [31:0] perf_conf_o;
  logic [31:0] perf_dm_o;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o), .if_ack_o(if_ack_o),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
    .dm_rdata_o(dm_rdata_o), .dm_ack_o(dm_ack_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
    .stall_o(stall_o), .err_o(err_o), .perf_conf_o(perf_conf_o), .perf_dm_o(perf_dm_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int unsigned n_chk = 0;
  int unsigned n_fail = 0;

  logic [31:0] ref_mem [256];   // reference view of memory contents
  logic [31:0] mem_arr [256];   // the memory model's storage
  int          dq[$];           // per-access ack delays, in expected service order
  acc_t        obs_log[$];      // accesses seen on the memory bus
  acc_t        exp_log[$];
  int          obs_rd = 0;
  int          rsp_mode = 0;    // 0 normal, 1 never ack, 2 stray ack
  int unsigned exp_conf = 0;
  int unsigned exp_dmcnt = 0;

  function automatic logic [31:0] init_word(input int unsigned i);
    return 32'((i * 32'h0101_0103) ^ 32'hA500_0000);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Memory responder: acks after the queued number of extra BUSY cycles.
  initial begin
    int rsp_idx, cur_d, busy;
    bit have_d;
    acc_t a;
    rsp_idx = 0; cur_d = 0; busy = 0; have_d = 0;
    for (int i = 0; i < 256; i++) mem_arr[i] = init_word(i);
    mem_ack_i = 1'b0;
    mem_rdata_i = '0;
    forever begin
      @(negedge clk_i);
      mem_ack_i = 1'b0;
      mem_rdata_i = '0;
      if (rsp_mode == 2) begin
        mem_ack_i = 1'b1;
        mem_rdata_i = 32'h1234_5678;
      end else if (rsp_mode == 0 && mem_req_o) begin
        if (!have_d) begin
          cur_d = (rsp_idx < dq.size()) ? dq[rsp_idx] : 0;
          rsp_idx++;
          have_d = 1;
        end
        if (busy >= cur_d) begin
          mem_ack_i = 1'b1;
          mem_rdata_i = mem_we_o ? 32'h0 : mem_arr[mem_addr_o[9:2]];
          a.we = mem_we_o;
          a.addr = mem_addr_o;
          a.wdata = mem_we_o ? mem_wdata_o : 32'h0;
          obs_log.push_back(a);
          if (mem_we_o) mem_arr[mem_addr_o[9:2]] = mem_wdata_o;
          have_d = 0;
          busy = 0;
        end else begin
          busy++;
        end
      end else if (!mem_req_o) begin
        have_d = 0;
        busy = 0;
      end
    end
  end

  // One request burst starting in IDLE; called at negedge+1, returns at negedge+2.
  task automatic burst(input bit do_if, input bit do_dm, input bit we,
                       input logic [31:0] ia, input logic [31:0] da, input logic [31:0] wd,
                       input int d_dm, input int d_if, input bit tmo);
    int exp_if, exp_dm, got_if, got_dm, n_if, n_dm, last, bad_idle;
    logic [31:0] er_if, er_dm, rd_if, rd_dm;
    acc_t e, o;
    exp_if = -1; exp_dm = -1; got_if = -1; got_dm = -1;
    n_if = 0; n_dm = 0; bad_idle = 0;
    er_if = '0; er_dm = '0; rd_if = '0; rd_dm = '0;
    if (do_dm) begin
      exp_dm = d_dm + 2;
      exp_dmcnt++;
      if (!tmo) begin
        er_dm = we ? 32'h0 : ref_mem[da[9:2]];
        dq.push_back(d_dm);
        e.we = we; e.addr = da; e.wdata = we ? wd : 32'h0;
        exp_log.push_back(e);
        if (we) ref_mem[da[9:2]] = wd;
      end
    end
    if (do_if) begin
      exp_if = do_dm ? d_dm + d_if + 4 : d_if + 2;
      er_if = ref_mem[ia[9:2]];
      dq.push_back(d_if);
      e.we = 1'b0; e.addr = ia; e.wdata = 32'h0;
      exp_log.push_back(e);
      if (do_dm) exp_conf += 32'(d_dm + 2);
    end
    last = (exp_if > exp_dm) ? exp_if : exp_dm;
    if_req_i = do_if; if_addr_i = ia;
    dm_req_i = do_dm; dm_we_i = we; dm_addr_i = da; dm_wdata_i = wd;
    for (int c = 0; c <= last + 2; c++) begin
      if (c > 0) begin
        @(negedge clk_i); #1;
        if (c == exp_if + 1) if_req_i = 1'b0;
        if (c == exp_dm + 1) dm_req_i = 1'b0;
      end
      #1;
      chk("stall", 32'(stall_o), 32'((if_req_i && c != exp_if) || (dm_req_i && c != exp_dm)));
      if (if_ack_o) begin n_if++; got_if = c; rd_if = if_rdata_o; end
      else if (if_rdata_o !== 32'h0) bad_idle++;
      if (dm_ack_o) begin n_dm++; got_dm = c; rd_dm = dm_rdata_o; end
      else if (dm_rdata_o !== 32'h0) bad_idle++;
    end
    if_req_i = 1'b0;
    dm_req_i = 1'b0;
    chk("if_ack_count", 32'(n_if), 32'(do_if));
    chk("dm_ack_count", 32'(n_dm), 32'(do_dm));
    chk("rdata_without_ack", 32'(bad_idle), 32'h0);
    if (do_if) begin
      chk("if_ack_cycle", 32'(got_if), 32'(exp_if));
      chk("if_rdata", rd_if, er_if);
    end
    if (do_dm) begin
      chk("dm_ack_cycle", 32'(got_dm), 32'(exp_dm));
      chk("dm_rdata", rd_dm, er_dm);
    end
    chk("mem_access_count", 32'(obs_log.size() - obs_rd), 32'(exp_log.size()));
    while (exp_log.size() > 0) begin
      e = exp_log.pop_front();
      if (obs_rd < obs_log.size()) begin
        o = obs_log[obs_rd];
        obs_rd++;
        chk("mem_addr", o.addr, e.addr);
        chk("mem_we", 32'(o.we), 32'(e.we));
        chk("mem_wdata", o.wdata, e.wdata);
      end
    end
    obs_rd = obs_log.size();
  endtask

  task automatic chk_perf(input string tag);
`ifdef MEM_PORT_ARBITER_PERF_EN
    chk({tag, "_perf_conf"}, perf_conf_o, exp_conf);
    chk({tag, "_perf_dm"}, perf_dm_o, exp_dmcnt);
`else
    chk({tag, "_perf_conf"}, perf_conf_o, 32'h0);
    chk({tag, "_perf_dm"}, perf_dm_o, 32'h0);
`endif
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_mem_req"}, 32'(mem_req_o), 32'h0);
    chk({tag, "_mem_we"}, 32'(mem_we_o), 32'h0);
    chk({tag, "_if_ack"}, 32'(if_ack_o), 32'h0);
    chk({tag, "_dm_ack"}, 32'(dm_ack_o), 32'h0);
    chk({tag, "_if_rdata"}, if_rdata_o, 32'h0);
    chk({tag, "_dm_rdata"}, dm_rdata_o, 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: observed no finish, expected finish");
    $fatal(1, "bench did not finish");
  end

  initial begin
    int unsigned sel;
    rst_i = 1'b0;
    if_req_i = 1'b0; if_addr_i = '0;
    dm_req_i = 1'b0; dm_we_i = 1'b0; dm_addr_i = '0; dm_wdata_i = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    repeat (3) @(negedge clk_i);
    #1;
    chk_quiet("reset");
    chk("reset_mem_addr", mem_addr_o, 32'h0);
    chk("reset_mem_wdata", mem_wdata_o, 32'h0);
    chk("reset_err", 32'(err_o), 32'h0);
    chk("reset_stall", 32'(stall_o), 32'h0);
    chk_perf("reset");
    rst_i = 1'b1;
    @(negedge clk_i); #1;

    // Fetch only, one-cycle memory turnaround.
    burst(1'b1, 1'b0, 1'b0, 32'h4, 32'h0, 32'h0, 0, 0, 1'b0);
    // Collision: data first, fetch granted from data's response cycle.
    burst(1'b1, 1'b1, 1'b0, 32'h8, 32'h20, 32'h0, 0, 0, 1'b0);
    // Store, then fetch the stored word back.
    burst(1'b0, 1'b1, 1'b1, 32'h0, 32'h10, 32'hDEAD_BEEF, 0, 0, 1'b0);
    burst(1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 32'h0, 1, 0, 1'b0);
    // Two data loads, each with a pending fetch.
    burst(1'b1, 1'b1, 1'b0, 32'h30, 32'h34, 32'h0, 1, 0, 1'b0);
    burst(1'b1, 1'b1, 1'b0, 32'h38, 32'h3C, 32'h0, 2, 1, 1'b0);
    chk_perf("directed");

    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(1, 3);
      burst(sel[0], sel[1], 1'($urandom_range(0, 1)),
            {22'h0, 8'($urandom_range(0, 255)), 2'b00},
            {22'h0, 8'($urandom_range(0, 255)), 2'b00},
            $urandom, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 1'b0);
    end
    chk_perf("random");
    chk("err_before_timeout", 32'(err_o), 32'h0);

    // Watchdog: memory never answers a data load.
    rsp_mode = 1;
    burst(1'b0, 1'b1, 1'b0, 32'h0, 32'h44, 32'h0, TMO - 1, 0, 1'b1);
    rsp_mode = 0;
    chk("err_after_timeout", 32'(err_o), 32'h1);
    burst(1'b1, 1'b0, 1'b0, 32'h48, 32'h0, 32'h0, 0, 0, 1'b0);
    chk("err_sticky", 32'(err_o), 32'h1);
    chk_perf("watchdog");

    // Reset during BUSY, then a stray memory ack.
    rsp_mode = 1;
    dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h40;
    @(negedge clk_i); #1;
    chk("pre_reset_busy", 32'(mem_req_o), 32'h1);
    rst_i = 1'b0;
    dm_req_i = 1'b0;
    @(negedge clk_i); #1;
    rst_i = 1'b1;
    rsp_mode = 2;
    exp_conf = 0;
    exp_dmcnt = 0;
    chk_quiet("after_reset");
    chk("after_reset_err", 32'(err_o), 32'h0);
    chk("after_reset_addr", mem_addr_o, 32'h0);
    chk_perf("after_reset");
    @(negedge clk_i); #1;
    rsp_mode = 0;
    chk_quiet("stray_ack");
    @(negedge clk_i); #1;
    chk_quiet("post_stray");
    obs_rd = obs_log.size();
    burst(1'b1, 1'b0, 1'b0, 32'h4C, 32'h0, 32'h0, 0, 0, 1'b0);
    burst(1'b1, 1'b1, 1'b0, 32'h50, 32'h54, 32'h0, 0, 0, 1'b0);
    chk_perf("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
